vram_fill_arbiter: RTL
======================

Name: vram_fill_arbiter

Overview:
- Owns the single write/read port of the VRAM block RAM on the memory-clock side.
- Shares that port between two requesters: the CPU memory bus and an internal rectangle-fill engine.
- The fill engine writes solid RGB444 rectangles one pixel per granted cycle.
- It sits between the CPU bus decoder and the dual-port VRAM; the VGA scan-out side is untouched.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles a busy fill engine may be denied before it is forced one grant.
- X_LEN, 8: pixel X coordinate width (256 pixels, two 16-bit pixels per 32-bit word).
- Y_LEN, 8: pixel Y coordinate width (256 lines).

Ports:
- mem_clk  in  1  clock for all logic
- rst_n  in  1  reset, asynchronous, active-low
- cpu_re  in  1  CPU read request
- cpu_we  in  4  CPU byte write strobes
- cpu_addr  in  15  CPU word address, i.e. byte address bits [16:2]
- cpu_wdata  in  32  CPU write data
- cpu_rdata  out  32  CPU read data, valid while cpu_ready=1
- cpu_ready  out  1  CPU access complete
- vram_re  out  1  VRAM read enable
- vram_we  out  4  VRAM byte write strobes
- vram_addr  out  15  VRAM word address: [14:7]=y, [6:0]=x>>1
- vram_wdata  out  32  VRAM write data
- vram_rdata  in  32  VRAM read data, valid one cycle after vram_re
- fill_x0  in  X_LEN  rectangle left edge
- fill_y0  in  Y_LEN  rectangle top edge
- fill_w  in  X_LEN+1  width in pixels
- fill_h  in  Y_LEN+1  height in lines
- fill_color  in  12  RGB444 fill colour
- fill_start  in  1  one-cycle start pulse
- fill_busy  out  1  fill in progress
- fill_done  out  1  one-cycle completion pulse

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; starve counter 0; no CPU access pending.
- CPU request: cpu_re=1 or cpu_we≠0. The CPU holds its request until it sees cpu_ready.
- Grant rules, per cycle:
  - CPU wins when it requests and is not in the ACK cycle.
  - The fill engine wins when CPU loses or is not requesting.
  - Exception: if starve_cnt==STARVE_LIMIT, the fill engine wins.
- starve_cnt:
  - increments when the engine is in RUN and not granted;
  - clears on a fill grant;
  - saturates at STARVE_LIMIT.
- CPU grant in cycle G:
  - vram_re=cpu_re, vram_we=cpu_we, vram_addr=cpu_addr, vram_wdata=cpu_wdata, all driven combinationally in G.
  - In G+1: cpu_ready=1 and cpu_rdata=vram_rdata.
  - In G+1 the still-asserted request is not re-granted, so the fill engine may use the port that cycle.
  - Latency is 1 cycle when uncontested.
- Fill grant:
  - vram_re=0; vram_addr={cy, cx[X_LEN-1:1]}; vram_wdata={4'b0, fill_color, 4'b0, fill_color}.
  - vram_we=4'b0011 if cx[0]==0, otherwise 4'b1100.
- FSM states:
  - IDLE: on fill_start, latch all fill_* inputs, cx=x0, cy=y0, col=0, row=0.
    - If w==0 or h==0, go to DONE; otherwise go to RUN.
  - RUN: each fill grant advances one pixel.
    - col increments and cx=cx+1 (mod 2^X_LEN).
    - When col==w-1: col=0, cx=x0, row increments, cy=cy+1 (mod 2^Y_LEN).
    - When the last pixel (row==h-1, col==w-1) is written, go to DONE.
  - DONE: fill_done=1 for exactly one cycle, then go to IDLE.
- fill_busy=1 in RUN and DONE.
- fill_start while busy is ignored. Input changes after latch have no effect.
- Coordinates wrap mod 2^X_LEN / 2^Y_LEN; there is no clipping.
- fill_start and a CPU request in the same cycle: CPU is granted, and the fill start latches normally.
- Reset asserted mid-fill: immediate return to IDLE, no fill_done, pending CPU ack dropped.

Optional Feature:
- FILL_ABORT_EN defined:
  - adds input port fill_abort (1 bit);
  - fill_abort=1 in RUN forces DONE on the next edge;
  - a pixel written in the same cycle completes; no further pixels are written;
  - fill_done still pulses;
  - fill_abort in IDLE or DONE is ignored.
- FILL_ABORT_EN undefined: the port is absent and a fill always runs to completion.

Test Plan:
- CPU-only traffic:
  - Write cpu_we=4'hF, addr 0x0123, data 0xDEADBEEF, then read the same address.
  - Required: vram_we=F on the grant cycle; cpu_ready one cycle later; read returns 0xDEADBEEF.
- Fill x0=3, y0=10, w=3, h=2, colour 0xABC, no CPU traffic:
  - Required: exactly 6 writes, in order (3,10) we=1100, (4,10) 0011, (5,10) 1100, then the same three at y=11.
  - Data is 0x0ABC0ABC; fill_done pulses once, 7 cycles after start.
- Wrap-around: x0=255, w=2, y0=255, h=2.
  - Required: writes to x=255 then x=0, with y=255 then y=0.
- Zero size: w=0, h=5.
  - Required: no VRAM write; fill_done one cycle after the IDLE→DONE transition; fill_busy high for exactly 1 cycle.
- Starvation: fill w=8, h=1 with a continuous CPU write request, STARVE_LIMIT=4.
  - Required: fill is granted at least once every 5 cycles.
  - Every CPU write gets cpu_ready exactly once per request.
- Reset and start-while-busy:
  - Drop rst_n during RUN. Required: all outputs 0 asynchronously and no fill_done.
  - Pulse fill_start while busy. Required: ignored, the original rectangle completes.
  - Abort (FILL_ABORT_EN only): fill_abort after 2 pixels. Required: 2 or 3 writes total, then fill_done.

Source files
------------

// File: rtl/vram_fill_arbiter.sv
// vram_fill_arbiter: owns the single memory-clock-side VRAM port and shares it
// between the CPU bus and a rectangle-fill engine. The engine writes RGB444
// pixels, one per granted cycle. A CPU access completes in the cycle after its
// grant. A fill engine that has been denied STARVE_LIMIT times in a row is
// given the port for one cycle.
// Optional build macro: FILL_ABORT_EN adds the fill_abort input. A fill then
// ends early at the next edge, after the pixel written in the current cycle.
module vram_fill_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int X_LEN        = 8,
  parameter int Y_LEN        = 8
) (
  input  logic             mem_clk,
  input  logic             rst_n,
  input  logic             cpu_re,
  input  logic [3:0]       cpu_we,
  input  logic [14:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_ready,
  output logic             vram_re,
  output logic [3:0]       vram_we,
  output logic [14:0]      vram_addr,
  output logic [31:0]      vram_wdata,
  input  logic [31:0]      vram_rdata,
  input  logic [X_LEN-1:0] fill_x0,
  input  logic [Y_LEN-1:0] fill_y0,
  input  logic [X_LEN:0]   fill_w,
  input  logic [Y_LEN:0]   fill_h,
  input  logic [11:0]      fill_color,
  input  logic             fill_start,
  output logic             fill_busy,
  output logic             fill_done
`ifdef FILL_ABORT_EN
  ,
  input  logic             fill_abort
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]    STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0]    STARVE_ONE = SW'(1);
  localparam logic [X_LEN-1:0] X_ONE      = X_LEN'(1);
  localparam logic [Y_LEN-1:0] Y_ONE      = Y_LEN'(1);
  localparam logic [X_LEN:0]   COL_ONE    = (X_LEN + 1)'(1);
  localparam logic [Y_LEN:0]   ROW_ONE    = (Y_LEN + 1)'(1);

  logic [1:0]       state;
  logic [SW-1:0]    starve_cnt;
  logic             cpu_ack;
  logic [X_LEN-1:0] x0_q;
  logic [X_LEN:0]   w_q;
  logic [Y_LEN:0]   h_q;
  logic [11:0]      color_q;
  logic [X_LEN-1:0] cx;
  logic [Y_LEN-1:0] cy;
  logic [X_LEN:0]   col;
  logic [Y_LEN:0]   row;

  logic cpu_req;
  logic starve_force;
  logic cpu_gnt;
  logic fill_gnt;
  logic last_col;
  logic last_row;
  logic abort_req;

`ifdef FILL_ABORT_EN
  assign abort_req = fill_abort;
`else
  assign abort_req = 1'b0;
`endif

  // Grant decision: the CPU wins unless it is in its ack cycle or the engine is starved.
  assign cpu_req      = cpu_re || (cpu_we != 4'h0);
  assign starve_force = (state == ST_RUN) && (starve_cnt == STARVE_MAX);
  // The CPU grant is gated by reset so that the port stays quiet while reset is held.
  assign cpu_gnt      = rst_n && cpu_req && !cpu_ack && !starve_force;
  assign fill_gnt     = (state == ST_RUN) && !cpu_gnt;

  assign last_col = (col == w_q - COL_ONE);
  assign last_row = (row == h_q - ROW_ONE);

  assign fill_busy = (state == ST_RUN) || (state == ST_DONE);
  assign fill_done = (state == ST_DONE);
  assign cpu_ready = cpu_ack;
  assign cpu_rdata = cpu_ack ? vram_rdata : 32'h0;

  // VRAM port mux: drive the winner's request in the cycle it is granted.
  always_comb begin
    // NOTE: every output gets a default first so that no path infers a latch.
    vram_re    = 1'b0;
    vram_we    = 4'h0;
    vram_addr  = 15'h0;
    vram_wdata = 32'h0;
    if (cpu_gnt) begin
      vram_re    = cpu_re;
      vram_we    = cpu_we;
      vram_addr  = cpu_addr;
      vram_wdata = cpu_wdata;
    end else if (fill_gnt) begin
      vram_we    = cx[0] ? 4'b1100 : 4'b0011;
      vram_addr  = 15'({cy, cx[X_LEN-1:1]});
      vram_wdata = {4'h0, color_q, 4'h0, color_q};
    end
  end

  // CPU ack flag and starvation counter.
  always_ff @(posedge mem_clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      cpu_ack    <= 1'b0;
      starve_cnt <= '0;
    end else begin
      cpu_ack <= cpu_gnt;
      if (fill_gnt || state != ST_RUN) begin
        starve_cnt <= '0;
      end else if (starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + STARVE_ONE;
      end
    end
  end

  // Fill FSM: latch the rectangle, then step one pixel per fill grant in raster order.
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      x0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
      cx      <= '0;
      cy      <= '0;
      col     <= '0;
      row     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fill_start) begin
            x0_q    <= fill_x0;
            w_q     <= fill_w;
            h_q     <= fill_h;
            color_q <= fill_color;
            cx      <= fill_x0;
            cy      <= fill_y0;
            col     <= '0;
            row     <= '0;
            state   <= (fill_w == '0 || fill_h == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (fill_gnt) begin
            if (last_col) begin
              col <= '0;
              cx  <= x0_q;
              row <= row + ROW_ONE;
              cy  <= cy + Y_ONE;
              if (last_row) state <= ST_DONE;
            end else begin
              col <= col + COL_ONE;
              cx  <= cx + X_ONE;
            end
          end
          if (abort_req) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
